// File: rtl/trip_interval_capture.sv
// Trip-sensor front end: synchronizes both trip inputs, measures edge-to-edge intervals per channel
// and hands completed pairs downstream over valid/ready. Optional macro TRIP_LOCKOUT_EN adds a post-edge lockout.
module trip_interval_capture #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 2000000,
    parameter int LOCKOUT     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tripone,
    input  logic             triptwo,
    input  logic             pair_ready,
    input  logic             clear_flags,
    output logic             pair_valid,
    output logic [CNT_W-1:0] count_one,
    output logic [CNT_W-1:0] count_two,
    output logic             overrun,
    output logic             timeout,
    output logic             saturated,
    output logic [1:0]       armed
);

    typedef enum logic {UNARMED, ARMED} chan_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [63:0]      TIMEOUT_W = 64'(TIMEOUT);

`ifdef TRIP_LOCKOUT_EN
    localparam int LOCK_LEN = LOCKOUT;
`else
    // Lockout disabled: the window collapses to zero and every edge is accepted.
    localparam int LOCK_LEN = 0 * LOCKOUT;
`endif
    localparam int LW = (LOCK_LEN > 0) ? $clog2(LOCK_LEN + 1) : 1;

    logic [1:0]                  trip_raw;
    logic [1:0][SYNC_STAGES-1:0] sync_q;
    logic [1:0]                  sync_prev;
    logic [1:0]                  edge_q;
    logic [1:0]                  accept;
    logic [1:0][LW-1:0]          lock_q;

    chan_state_t                 state_q [2];
    chan_state_t                 state_d [2];
    logic [1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [1:0][CNT_W-1:0]       cap_q, cap_d;
    logic [1:0]                  done_q, done_d;
    logic [1:0]                  ovr_e, tmo_e, sat_e;
    logic                        xfer;

    assign trip_raw = {triptwo, tripone};

    // Synchronizer chain and registered rising-edge detector; a held level yields one pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= '0;
            sync_prev <= '0;
            edge_q    <= '0;
            lock_q    <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                sync_q[i]    <= {sync_q[i][SYNC_STAGES-2:0], trip_raw[i]};
                sync_prev[i] <= sync_q[i][SYNC_STAGES-1];
                edge_q[i]    <= sync_q[i][SYNC_STAGES-1] & ~sync_prev[i];
                if (accept[i])
                    lock_q[i] <= LW'(LOCK_LEN);
                else if (lock_q[i] != '0)
                    lock_q[i] <= lock_q[i] - LW'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++)
            accept[i] = edge_q[i] && (lock_q[i] == '0);
    end

    // A pair moves to the output slot once both channels hold a capture and the slot frees up.
    assign xfer = done_q[0] & done_q[1] & (~pair_valid | pair_ready);

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            cap_d[i]   = cap_q[i];
            done_d[i]  = xfer ? 1'b0 : done_q[i];
            ovr_e[i]   = 1'b0;
            tmo_e[i]   = 1'b0;
            sat_e[i]   = 1'b0;
            case (state_q[i])
                UNARMED: begin
                    if (accept[i]) begin
                        cnt_d[i]   = CNT_ONE;
                        state_d[i] = ARMED;
                    end
                end
                ARMED: begin
                    if (accept[i]) begin
                        // A capture landing in the transfer cycle replaces cleanly, no overrun.
                        cap_d[i]  = cnt_q[i];
                        done_d[i] = 1'b1;
                        cnt_d[i]  = CNT_ONE;
                        ovr_e[i]  = done_q[i] & ~xfer;
                    end else if (64'(cnt_q[i]) == TIMEOUT_W) begin
                        state_d[i] = UNARMED;
                        tmo_e[i]   = 1'b1;
                    end else if (cnt_q[i] != CNT_MAX) begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                        sat_e[i] = (cnt_q[i] == CNT_MAX - CNT_ONE);
                    end
                end
                default: state_d[i] = UNARMED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++)
                state_q[i] <= UNARMED;
            cnt_q  <= '0;
            cap_q  <= '0;
            done_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++)
                state_q[i] <= state_d[i];
            cnt_q  <= cnt_d;
            cap_q  <= cap_d;
            done_q <= done_d;
        end
    end

    // Output slot and sticky flags; a new event wins over a coincident clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            pair_valid <= 1'b0;
            count_one  <= '0;
            count_two  <= '0;
            overrun    <= 1'b0;
            timeout    <= 1'b0;
            saturated  <= 1'b0;
        end else begin
            if (xfer) begin
                count_one  <= cap_q[0];
                count_two  <= cap_q[1];
                pair_valid <= 1'b1;
            end else if (pair_valid && pair_ready) begin
                pair_valid <= 1'b0;
            end
            overrun   <= (|ovr_e) | (overrun   & ~clear_flags);
            timeout   <= (|tmo_e) | (timeout   & ~clear_flags);
            saturated <= (|sat_e) | (saturated & ~clear_flags);
        end
    end

    assign armed = {state_q[1] == ARMED, state_q[0] == ARMED};

endmodule

// File: doc/trip_interval_capture.md
Name: trip_interval_capture

Overview:
- Upstream front end for xyLocation: conditions the two raw trip-sensor inputs and measures the clock-cycle interval between consecutive trips on each channel.
- Presents each completed pair of intervals to xyLocation through a valid/ready handshake.
- Reports overrun, timeout and saturation as sticky status flags.

Parameters:
- CNT_W, 32: width of the interval counters and of count_one / count_two.
- SYNC_STAGES, 2: synchronizer depth per trip input, minimum 2.
- TIMEOUT, 2000000: cycles an armed channel waits for its next edge before disarming.
- LOCKOUT, 16: post-edge ignore window in cycles; used only when TRIP_LOCKOUT_EN is defined.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- tripone  in  1  raw trip sensor 1, asynchronous, pulse width at least 1 clk.
- triptwo  in  1  raw trip sensor 2, asynchronous, pulse width at least 1 clk.
- pair_ready  in  1  consumer accepts the pair.
- clear_flags  in  1  one-cycle pulse that clears all sticky flags.
- pair_valid  out  1  count_one / count_two hold a valid pair.
- count_one  out  CNT_W  channel 1 interval in cycles.
- count_two  out  CNT_W  channel 2 interval in cycles.
- overrun  out  1  sticky: a capture was overwritten before it was transferred.
- timeout  out  1  sticky: a channel disarmed on TIMEOUT.
- saturated  out  1  sticky: a counter reached its maximum value.
- armed  out  2  per-channel armed state; bit0 = channel 1.

Behaviour:
- Reset:
  - all outputs are 0; counters, capture registers and done bits are 0; synchronizers are cleared; both channels UNARMED.
  - reset asserted mid-measurement discards all state; no pair is emitted for edges seen before reset.
- Input conditioning:
  - each trip input passes through SYNC_STAGES flops, then a rising-edge detector produces a 1-cycle pulse.
  - the pulse occurs SYNC_STAGES+1 clock edges after the first edge that samples the raw input high.
  - a level held high produces a single edge.
- Per-channel FSM:
  - UNARMED: on an edge, load counter = 1, go to ARMED, capture nothing.
  - ARMED, on an edge: capture register <= counter, done <= 1, counter <= 1. The interval equals the cycle distance between the two edge pulses.
  - ARMED, no edge: counter increments, saturating at 2^CNT_W-1. On reaching saturation, saturated <= 1.
  - ARMED, counter reaches TIMEOUT with no edge: go to UNARMED, timeout <= 1, done unchanged.
  - an edge that occurs while done is already 1 overwrites the capture register and sets overrun <= 1.
- Output slot:
  - when both done bits are 1 and the slot is empty (pair_valid = 0, or pair_valid && pair_ready this cycle), on the next edge:
    - load count_one / count_two from the capture registers;
    - set pair_valid = 1;
    - clear both done bits.
  - pair_valid rises 1 cycle after the later channel's capture.
  - pair_valid stays high and the counts stay stable until pair_ready is sampled high; the slot empties on that edge.
  - transfer and a new edge on the same channel in the same cycle: the old capture is transferred, the new value is latched, and done ends at 1 (set has priority over clear). No overrun is flagged.
- Flags:
  - overrun, timeout and saturated are sticky until clear_flags or reset.
  - if clear_flags coincides with a new flag event, the flag ends at 1.

Optional Feature:
- TRIP_LOCKOUT_EN defined:
  - after each accepted edge, further edges on that channel are ignored for LOCKOUT cycles.
  - the counter keeps running during the lockout.
  - ignored edges set no flags.
- TRIP_LOCKOUT_EN undefined: every detected edge is accepted.

Test Plan:
- Reset, then single-cycle pulses on both trips every 1000 cycles, pair_ready tied high -> first pulses arm only; every later pulse yields pair_valid for 1 cycle with count_one = count_two = 1000.
- tripone period 500, triptwo period 800, pair_ready high -> each pair reports 500 / 800; pair_valid follows the later channel's capture by 1 cycle.
- pair_ready held low across three channel-1 captures -> pair_valid stays high with the first pair stable; overrun = 1. Then clear_flags -> overrun = 0.
- Arm channel 1, then no further tripone for TIMEOUT = 100 (override) cycles -> armed[0] = 0 and timeout = 1; the next tripone only re-arms.
- Reset asserted between the arming edge and the second edge -> no pair_valid; all outputs 0 the following cycle.
- With TRIP_LOCKOUT_EN, LOCKOUT = 16: second tripone pulse 10 cycles after the first -> ignored; the next pulse at 1000 cycles reports 1000. Without the macro, the same stimulus reports 10 (then 990).
